// File: rtl/fetch_unit.sv
// Fetch stage: PC, credit-limited imem req/gnt/rvalid, {instr,pc} buffer to decode; gnt N -> instr_valid_o N+2.
// Backpressure: imem_req_o drops when outstanding + buffered words reach FIFO_DEPTH; redirect flushes and discards in-flight data.
module fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_gnt_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        instr_valid_o,
  input  logic        instr_ready_i,
  output logic [31:0] instr_o,
  output logic [31:0] pc_o
);
  localparam int          CW    = $clog2(FIFO_DEPTH + 1);
  localparam logic [CW:0] DEPTH = (CW + 1)'(FIFO_DEPTH);
  localparam logic [31:0] NOP   = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } entry_t;

  localparam entry_t IDLE = '{instr: NOP, pc: 32'h0};

  logic [31:0]   pc;
  logic          run;
  logic [CW-1:0] outstanding, outstanding_nxt, discard, count, count_nxt;
  logic [31:0]   qpc [FIFO_DEPTH];
  logic [31:0]   qpc_nxt [FIFO_DEPTH];
  entry_t        fifo [FIFO_DEPTH];
  entry_t        fifo_nxt [FIFO_DEPTH];
  entry_t        head;
  logic          valid;
  logic          grant, resp, push, pop;
  logic [CW:0]   inflight;

  // Every granted request owns a buffer slot until its word leaves to decode.
  assign inflight      = {1'b0, outstanding} + {1'b0, count};
  assign imem_req_o    = run && (inflight < DEPTH);
  assign imem_addr_o   = pc;
  assign grant         = imem_req_o & imem_gnt_i;
  assign resp          = imem_rvalid_i & (outstanding != '0);
  assign push          = resp & (discard == '0) & ~redirect_i;
  assign pop           = valid & instr_ready_i;
  assign instr_valid_o = valid;
  assign instr_o       = head.instr;
  assign pc_o          = head.pc;

  always_comb begin
    outstanding_nxt = outstanding + CW'(grant) - CW'(resp);
    qpc_nxt = qpc;
    if (resp) begin
      for (int i = 0; i < FIFO_DEPTH - 1; i++) qpc_nxt[i] = qpc[i+1];
    end
    if (grant) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        if (CW'(i) == outstanding - CW'(resp)) qpc_nxt[i] = pc;
      end
    end

    fifo_nxt  = fifo;
    count_nxt = count;
    if (pop) begin
      for (int i = 0; i < FIFO_DEPTH - 1; i++) fifo_nxt[i] = fifo[i+1];
      count_nxt = count - CW'(1);
    end
    if (push) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        if (CW'(i) == count_nxt) fifo_nxt[i] = {imem_rdata_i, qpc[0]};
      end
      count_nxt = count_nxt + CW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      pc          <= RESET_PC;
      run         <= 1'b0;
      outstanding <= '0;
      discard     <= '0;
      count       <= '0;
      valid       <= 1'b0;
      head        <= IDLE;
    end else begin
      run         <= 1'b1;
      outstanding <= outstanding_nxt;
      qpc         <= qpc_nxt;
      fifo        <= fifo_nxt;
      if (redirect_i) begin
        pc      <= {redirect_pc_i[31:2], 2'b00};
        discard <= outstanding_nxt;
        count   <= '0;
        valid   <= 1'b0;
        head    <= IDLE;
      end else begin
        if (grant) pc <= pc + 32'd4;
        if (resp && discard != '0) discard <= discard - CW'(1);
        count <= count_nxt;
        valid <= (count_nxt != '0);
        head  <= (count_nxt != '0) ? fifo_nxt[0] : IDLE;
      end
    end
  end
endmodule
